// File: rtl/vram_fifo_port.sv
// VRAM access port: buffers game-side writes and prefetched reads in front of a
// single-outstanding req/ack memory. Writes always win over reads.
module vram_fifo_port #(
    parameter int WR_DEPTH  = 16,
    parameter int RD_DEPTH  = 16,
    parameter int RD_BURST  = 10,
    parameter int ADDR_STEP = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        write_ld,
    input  logic        write_req,
    input  logic [24:0] writeaddr,
    input  logic [15:0] writedata,
    input  logic        read_ld,
    input  logic        read_req,
    input  logic [24:0] readaddr,
    output logic [15:0] readdata,
    output logic [15:0] wr_buffer,
    output logic [15:0] rd_buffer,
    output logic        wr_overflow,
    output logic        mem_req,
    output logic        mem_we,
    output logic [24:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata
);
    localparam int WAW = $clog2(WR_DEPTH);
    localparam int RAW = $clog2(RD_DEPTH);
    localparam logic [WAW:0] WR_FULL = (WAW+1)'(WR_DEPTH);
    localparam logic [RAW:0] RD_FULL = (RAW+1)'(RD_DEPTH);
    localparam logic [24:0]  STEP    = 25'(ADDR_STEP);
    localparam logic [15:0]  BURST   = 16'(RD_BURST);

    typedef enum logic [1:0] {IDLE, WR, RD} state_t;
    state_t state, state_nxt;

    logic [15:0]    wr_mem [WR_DEPTH];
    logic [WAW-1:0] wr_head, wr_tail;
    logic [WAW:0]   wr_count;
    logic [24:0]    wr_ptr;
    logic           wr_stale;

    logic [15:0]    rd_mem [RD_DEPTH];
    logic [RAW-1:0] rd_head, rd_tail;
    logic [RAW:0]   rd_count;
    logic [24:0]    rd_ptr;
    logic [15:0]    fetch_left;
    logic           rd_discard;

    logic issue_wr, issue_rd, wr_ack, rd_ack;
    logic wr_full, wr_pop, wr_push, wr_drop;
    logic rd_push, rd_pop;

    // A load in the current cycle holds off issue so the new pointer is used.
    always_comb begin
        state_nxt = state;
        issue_wr  = 1'b0;
        issue_rd  = 1'b0;
        wr_ack    = 1'b0;
        rd_ack    = 1'b0;
        case (state)
            IDLE: begin
                if (!write_ld && !read_ld) begin
                    if (wr_count != '0) begin
                        issue_wr  = 1'b1;
                        state_nxt = WR;
                    end else if (fetch_left != '0 && rd_count < RD_FULL) begin
                        issue_rd  = 1'b1;
                        state_nxt = RD;
                    end
                end
            end
            WR: begin
                if (mem_ack) begin
                    wr_ack    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            RD: begin
                if (mem_ack) begin
                    rd_ack    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    assign mem_req = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (issue_wr) begin
            mem_we    <= 1'b1;
            mem_addr  <= wr_ptr;
            mem_wdata <= wr_mem[wr_head];
        end else if (issue_rd) begin
            mem_we    <= 1'b0;
            mem_addr  <= rd_ptr;
        end
    end

    // Write FIFO. The in-flight word stays at the head until its ack; a stale
    // in-flight write (flushed by write_ld) is tracked separately by wr_stale.
    assign wr_full = (wr_count == WR_FULL);
    assign wr_pop  = wr_ack && !wr_stale && !write_ld;
    assign wr_push = write_req && (write_ld || !wr_full || wr_pop);
    assign wr_drop = write_req && !write_ld && wr_full && !wr_pop;

    always_ff @(posedge clk) begin
        if (wr_push) wr_mem[write_ld ? '0 : wr_tail] <= writedata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_head     <= '0;
            wr_tail     <= '0;
            wr_count    <= '0;
            wr_ptr      <= '0;
            wr_overflow <= 1'b0;
            wr_stale    <= 1'b0;
        end else if (write_ld) begin
            wr_head     <= '0;
            wr_tail     <= WAW'(wr_push);
            wr_count    <= (WAW+1)'(wr_push);
            wr_ptr      <= writeaddr;
            wr_overflow <= 1'b0;
            wr_stale    <= (state == WR) && !mem_ack;
        end else begin
            if (wr_push) wr_tail <= wr_tail + WAW'(1);
            if (wr_pop) begin
                wr_head <= wr_head + WAW'(1);
                wr_ptr  <= wr_ptr + STEP;
            end
            if (wr_push && !wr_pop)      wr_count <= wr_count + (WAW+1)'(1);
            else if (!wr_push && wr_pop) wr_count <= wr_count - (WAW+1)'(1);
            if (wr_drop) wr_overflow <= 1'b1;
            if (wr_ack)  wr_stale    <= 1'b0;
        end
    end

    assign wr_buffer = 16'(wr_count) + 16'(wr_stale);

    // Read FIFO. A discarded or same-cycle-reloaded response neither pushes
    // nor advances rd_ptr, so rd_ptr stays at the freshly loaded readaddr.
    assign rd_push = rd_ack && !rd_discard && !read_ld;
    assign rd_pop  = read_req && (rd_count != '0) && !read_ld;

    always_ff @(posedge clk) begin
        if (rd_push) rd_mem[rd_tail] <= mem_rdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_head    <= '0;
            rd_tail    <= '0;
            rd_count   <= '0;
            rd_ptr     <= '0;
            fetch_left <= '0;
            rd_discard <= 1'b0;
        end else if (read_ld) begin
            rd_head    <= '0;
            rd_tail    <= '0;
            rd_count   <= '0;
            rd_ptr     <= readaddr;
            fetch_left <= BURST;
            rd_discard <= (state == RD) && !mem_ack;
        end else begin
            if (rd_push) begin
                rd_tail    <= rd_tail + RAW'(1);
                rd_ptr     <= rd_ptr + STEP;
                fetch_left <= fetch_left - 16'd1;
            end
            if (rd_pop) rd_head <= rd_head + RAW'(1);
            if (rd_push && !rd_pop)      rd_count <= rd_count + (RAW+1)'(1);
            else if (!rd_push && rd_pop) rd_count <= rd_count - (RAW+1)'(1);
            if (rd_ack) rd_discard <= 1'b0;
        end
    end

    assign rd_buffer = 16'(rd_count);
    assign readdata  = (rd_count == '0) ? 16'h0000 : rd_mem[rd_head];

endmodule

// File: tb/tb_vram_fifo_port.sv
// Directed bench for vram_fifo_port with a latency-configurable req/ack memory model.
module tb_vram_fifo_port;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        write_ld = 1'b0, write_req = 1'b0, read_ld = 1'b0, read_req = 1'b0;
    logic [24:0] writeaddr = '0, readaddr = '0;
    logic [15:0] writedata = '0;
    logic [15:0] readdata, wr_buffer, rd_buffer, mem_wdata;
    logic        wr_overflow, mem_req, mem_we;
    logic [24:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;

    int errors = 0;
    int checks = 0;
    int ack_lat = 1;
    bit stall = 1'b0;
    int lat_cnt;
    int wr_peak = 0;

    logic [15:0] mem_model [1024];
    logic [24:0] log_addr [$];
    logic [15:0] log_data [$];
    logic        log_we [$];
    logic [15:0] exp_q [$];

    vram_fifo_port dut (
        .clk(clk), .reset(reset),
        .write_ld(write_ld), .write_req(write_req), .writeaddr(writeaddr), .writedata(writedata),
        .read_ld(read_ld), .read_req(read_req), .readaddr(readaddr), .readdata(readdata),
        .wr_buffer(wr_buffer), .rd_buffer(rd_buffer), .wr_overflow(wr_overflow),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    // clock / reset
    always #5 clk = ~clk;

    // memory model: ack after ack_lat cycles of mem_req, none while stalled
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_ack   <= 1'b0;
            mem_rdata <= '0;
            lat_cnt   <= 0;
        end else begin
            mem_ack <= 1'b0;
            if (mem_req && !mem_ack && !stall) begin
                if (lat_cnt + 1 >= ack_lat) begin
                    mem_ack <= 1'b1;
                    lat_cnt <= 0;
                    log_addr.push_back(mem_addr);
                    log_we.push_back(mem_we);
                    if (mem_we) begin
                        mem_model[mem_addr[10:1]] = mem_wdata;
                        log_data.push_back(mem_wdata);
                    end else begin
                        mem_rdata <= mem_model[mem_addr[10:1]];
                        log_data.push_back(mem_model[mem_addr[10:1]]);
                    end
                end else begin
                    lat_cnt <= lat_cnt + 1;
                end
            end
        end
    end

    always @(negedge clk) if (int'(wr_buffer) > wr_peak) wr_peak = int'(wr_buffer);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // driver tasks: inputs change on the falling edge
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic do_write_ld(input logic [24:0] a);
        writeaddr = a; write_ld = 1'b1; tick(1); write_ld = 1'b0;
    endtask

    task automatic push_word(input logic [15:0] d);
        writedata = d; write_req = 1'b1; tick(1); write_req = 1'b0;
    endtask

    task automatic do_read_ld(input logic [24:0] a);
        readaddr = a; read_ld = 1'b1; tick(1); read_ld = 1'b0;
    endtask

    task automatic clear_log;
        log_addr.delete(); log_data.delete(); log_we.delete();
    endtask

    task automatic drain_reads(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            check(tag, readdata, exp_q.pop_front());
            read_req = 1'b1; tick(1); read_req = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        for (int i = 0; i < 1024; i++) mem_model[i] = 16'(i);
        tick(2);
        check("rst_mem_req", mem_req, 0);
        check("rst_wr_buffer", wr_buffer, 0);
        check("rst_rd_buffer", rd_buffer, 0);
        check("rst_readdata", readdata, 0);
        check("rst_overflow", wr_overflow, 0);
        check("rst_mem_addr", mem_addr, 0);
        reset = 1'b0;
        tick(2);

        // sequential write burst, 3-cycle memory
        ack_lat = 3; wr_peak = 0; clear_log();
        do_write_ld(25'h02A);
        for (int i = 0; i < 4; i++) push_word(16'h0FFF);
        n = 0;
        while (log_addr.size() < 4 && n < 200) begin tick(1); n++; end
        check("t1_buf_at_last_ack", wr_buffer, 1);
        tick(1);
        check("t1_buf_drained", wr_buffer, 0);
        check("t1_peak", wr_peak, 4);
        check("t1_nwrites", log_addr.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check("t1_addr", log_addr[i], 32'h2A + 32'(2 * i));
            check("t1_data", mem_model[10'h15 + 10'(i)], 16'h0FFF);
        end

        // row prefetch: word[n] = n
        clear_log();
        do_read_ld(25'h14);
        n = 0;
        while (rd_buffer != 16'h000A && n < 300) begin tick(1); n++; end
        tick(4);
        check("t2_fill", rd_buffer, 16'h000A);
        check("t2_nreads", log_addr.size(), 10);
        check("t2_first_addr", log_addr[0], 25'h14);
        check("t2_last_addr", log_addr[9], 25'h26);
        for (int i = 0; i < 10; i++) exp_q.push_back(16'h000A + 16'(i));
        drain_reads("t2_rdata", 10);
        check("t2_empty", rd_buffer, 0);
        check("t2_readdata_zero", readdata, 0);
        read_req = 1'b1; tick(1); read_req = 1'b0;
        check("t2_pop_empty", rd_buffer, 0);

        // overflow with acks stalled, then flush with a stale in-flight write
        stall = 1'b1; ack_lat = 1; clear_log();
        do_write_ld(25'h100);
        for (int i = 0; i < 17; i++) push_word(16'(i));
        check("t3_overflow", wr_overflow, 1);
        check("t3_buf_full", wr_buffer, 16);
        do_write_ld(25'h200);
        check("t3_overflow_clr", wr_overflow, 0);
        check("t3_buf_inflight", wr_buffer, 1);
        stall = 1'b0;
        n = 0;
        while (log_addr.size() < 1 && n < 50) begin tick(1); n++; end
        tick(2);
        check("t3_stale_addr", log_addr[0], 25'h100);
        check("t3_stale_data", log_data[0], 16'h0000);
        check("t3_buf_zero", wr_buffer, 0);
        check("t3_no_extra", log_addr.size(), 1);
        push_word(16'hBEEF);
        n = 0;
        while (log_addr.size() < 2 && n < 50) begin tick(1); n++; end
        check("t3_new_addr", log_addr[1], 25'h200);
        check("t3_new_data", log_data[1], 16'hBEEF);

        // writes and a read burst together: writes first, read sees new data
        tick(3); clear_log();
        writeaddr = 25'h40; writedata = 16'hA001; write_ld = 1'b1; write_req = 1'b1;
        tick(1); write_ld = 1'b0;
        writedata = 16'hA002; tick(1);
        writedata = 16'hA003; readaddr = 25'h40; read_ld = 1'b1;
        tick(1); write_req = 1'b0; read_ld = 1'b0;
        n = 0;
        while (rd_buffer != 16'h000A && n < 300) begin tick(1); n++; end
        tick(3);
        check("t4_nops", log_addr.size(), 13);
        check("t4_op0_we", log_we[0], 1);
        check("t4_op2_we", log_we[2], 1);
        check("t4_op3_rd", log_we[3], 0);
        exp_q.push_back(16'hA001); exp_q.push_back(16'hA002); exp_q.push_back(16'hA003);
        for (int i = 0; i < 7; i++) exp_q.push_back(16'h0023 + 16'(i));
        drain_reads("t4_rdata", 10);

        // read_ld while a read is outstanding
        ack_lat = 5; clear_log();
        do_read_ld(25'h80);
        n = 0;
        while (!(mem_req && !mem_we) && n < 50) begin tick(1); n++; end
        check("t5_rd_outstanding", mem_req && !mem_we, 1);
        do_read_ld(25'h0A0);
        n = 0;
        while (rd_buffer != 16'h000A && n < 400) begin tick(1); n++; end
        tick(10);
        check("t5_fill", rd_buffer, 16'h000A);
        check("t5_nreads", log_addr.size(), 11);
        check("t5_stale_addr", log_addr[0], 25'h80);
        check("t5_new_first", log_addr[1], 25'h0A0);
        check("t5_new_last", log_addr[10], 25'h0B2);
        check("t5_idle", mem_req, 0);
        for (int i = 0; i < 10; i++) exp_q.push_back(16'h0050 + 16'(i));
        drain_reads("t5_rdata", 10);

        // reset mid-write with reads buffered and writes queued
        ack_lat = 1;
        do_read_ld(25'h0);
        n = 0;
        while (rd_buffer != 16'h000A && n < 300) begin tick(1); n++; end
        stall = 1'b1;
        do_write_ld(25'h300);
        for (int i = 0; i < 3; i++) push_word(16'h5500 + 16'(i));
        check("t6_pre_req", mem_req && mem_we, 1);
        check("t6_pre_buf", wr_buffer, 3);
        check("t6_pre_rdbuf", rd_buffer, 16'h000A);
        reset = 1'b1;
        #1;
        check("t6_req_dropped", mem_req, 0);
        check("t6_wr_buffer", wr_buffer, 0);
        check("t6_rd_buffer", rd_buffer, 0);
        check("t6_readdata", readdata, 0);
        tick(1);
        reset = 1'b0; stall = 1'b0; clear_log();
        tick(10);
        check("t6_no_spurious", log_addr.size(), 0);
        check("t6_req_idle", mem_req, 0);
        do_write_ld(25'h310);
        push_word(16'h1234);
        n = 0;
        while (log_addr.size() < 1 && n < 50) begin tick(1); n++; end
        tick(2);
        check("t6_resume_addr", log_addr[0], 25'h310);
        check("t6_resume_mem", mem_model[10'h188], 16'h1234);
        check("t6_resume_buf", wr_buffer, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
